coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Front-end stage for the vending FSM. Drives that FSM's 'coins' input; consumes its 'open' output.
//  Synchronises and debounces the raw nickel/dime sensor lines.
//  Turns each accepted coin into a one-cycle code: 2'b01 = 5c, 2'b10 = 10c, 2'b00 = idle. 2'b11 is never emitted.
//  While 'open' is high, holds one coin; rejects ambiguous or overflowing insertions.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive synchronised cycles a new level must persist before it is accepted (>=1)
//  CNT_W            3  debounce counter width; must hold DEBOUNCE_CYCLES-1
//  REJ_W            8  width of saturating reject counter
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-high; clears all state
//  nickel_in   in   1      raw 5c sensor, asynchronous, may bounce
//  dime_in     in   1      raw 10c sensor, asynchronous, may bounce
//  open        in   1      vend FSM open flag; high = FSM busy vending
//  coins       out  2      registered coin code to the vend FSM; at most one cycle per coin
//  reject      out  1      registered one-cycle pulse: coin returned to user
//  reject_cnt  out  REJ_W  saturating count of reject pulses
// BEHAVIOUR
//  Reset values: coins=00, reject=0, reject_cnt=0.
//  Reset also clears: sync flops, debounced levels, debounce counters, pending slot; state=EMPTY.
//  Sync stage: 2-flop synchroniser per line (s1, s2).
//  Debounce stage, per channel:
//   - On each edge with s2!=deb: cnt increments.
//   - On an edge with s2!=deb and cnt==DEBOUNCE_CYCLES-1: deb<=s2, cnt<=0.
//   - Any edge with s2==deb: cnt<=0.
//   - A pulse shorter than DEBOUNCE_CYCLES cycles at s2 is ignored.
//  Event: ev_n / ev_d is registered, high for one cycle at the edge where that channel's deb goes 0->1.
//   Falling deb generates no event.
//  Latency: raw high first sampled at edge k -> coins valid after edge k+DEBOUNCE_CYCLES+3 (default 7) when idle.
//  Classification of each cycle's events:
//   - ev_n&ev_d: reject=1, nothing queued.
//   - ev_n only: code 01.
//   - ev_d only: code 10.
//  FSM, 2 states: EMPTY, PENDING (1-entry slot pend_code). Per edge, with new = classified code (or none):
//   - EMPTY,   open=0, new: coins<=new; stay EMPTY.
//   - EMPTY,   open=1, new: pend_code<=new -> PENDING; coins<=00.
//   - PENDING, open=1, new: reject=1; pend_code kept; stay PENDING.
//   - PENDING, open=0: coins<=pend_code.
//      If new: pend_code<=new, stay PENDING. Else -> EMPTY.
//   - PENDING, open=1, no new: hold.
//   - Otherwise: coins<=00.
//  Ordering: pending coin always emitted before a same-cycle new coin; coins delivered in arrival order.
//  Output timing: coins never 01/10 on two consecutive cycles unless two distinct coins were accepted.
//   No code is issued on any cycle in which open=1.
//  reject_cnt: +1 per reject pulse; saturates at all-ones, never wraps.
//  Reset mid-operation: pending coin and partial debounce discarded.
//   A sensor still held high after reset debounces again and yields one event.
// TESTING
//  1 nickel_in=1 for 10 cycles from edge 0, open=0 -> coins=01 exactly at cycle 7; coins=00 otherwise; reject=0.
//  2 dime_in=1 for 2 cycles (glitch) -> coins stays 00, reject=0, reject_cnt=0.
//  3 nickel_in and dime_in both rise on same cycle, held 10 cycles -> reject=1 for one cycle; coins stays 00; reject_cnt=1.
//  4 open=1 for 12 cycles; dime_in pulse of 8 cycles inside that window -> coins=00 throughout; coins=10 on the cycle after open falls.
//  5 dime pending, open still 1, then nickel pulse -> reject pulse; after open falls coins=10 once, no 01.
//  6 reset asserted mid-debounce and while PENDING -> next cycle all outputs 0; no stale code after release.
//  7 drive 256 rejects -> reject_cnt=255, stays 255.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor lines and the vend FSM 'open' flag in,
// coin code, reject pulse and reject count out.
interface coin_acceptor_if #(
   parameter int REJ_W = 8
) ();
   logic             nickel_in;
   logic             dime_in;
   logic             open;
   logic [1:0]       coins;
   logic             reject;
   logic [REJ_W-1:0] reject_cnt;

   // Environment side: drives the sensors and the open flag, observes results.
   modport master (
      output nickel_in,
      output dime_in,
      output open,
      input  coins,
      input  reject,
      input  reject_cnt
   );

   // Acceptor side.
   modport slave (
      input  nickel_in,
      input  dime_in,
      input  open,
      output coins,
      output reject,
      output reject_cnt
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end for the vending FSM.
// Synchronises and debounces the nickel/dime sensors, turns each accepted
// coin into a one-cycle code on 'coins', and parks one coin while the vend
// FSM is busy ('open' high). Ambiguous or overflowing insertions are rejected.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   EMPTY   | no coin parked; new coins pass straight through when open=0
//   PENDING | one coin parked in pend_code, released once open drops
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3,
   parameter int REJ_W           = 8
) (
   input  logic            clk,
   input  logic            reset,
   coin_acceptor_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       CODE_NONE = 2'b00;

   typedef enum logic {
      EMPTY   = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Channel index 0 = nickel, 1 = dime, so an event vector doubles as
   // the coin code (01 = 5c, 10 = 10c).
   logic [1:0]       raw;
   logic [1:0]       s1;
   logic [1:0]       s2;
   logic [1:0]       deb;
   logic [1:0]       deb_d;
   logic [1:0]       ev;
   logic [CNT_W-1:0] cnt [2];

   state_t           state;
   logic [1:0]       pend_code;
   logic [1:0]       coins_q;
   logic             reject_q;
   logic [REJ_W-1:0] reject_cnt_q;

   logic             ev_both;
   logic             new_valid;
   logic [1:0]       new_code;
   logic             reject_nxt;

   assign raw = {bus.dime_in, bus.nickel_in};

   // Two-flop synchroniser, per-channel debounce and rising-level event.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= '0;
         s2     <= '0;
         deb    <= '0;
         deb_d  <= '0;
         ev     <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb_d <= deb;
         ev    <= deb & ~deb_d;
         for (int ch = 0; ch < 2; ch++) begin
            if (s2[ch] != deb[ch]) begin
               if (cnt[ch] == CNT_TC) begin
                  deb[ch] <= s2[ch];
                  cnt[ch] <= '0;
               end else begin
                  cnt[ch] <= cnt[ch] + 1'b1;
               end
            end else begin
               cnt[ch] <= '0;
            end
         end
      end
   end

   // Classify this cycle's events; simultaneous nickel+dime is ambiguous.
   always_comb begin
      ev_both    = ev[0] & ev[1];
      new_valid  = ev[0] ^ ev[1];
      new_code   = new_valid ? ev : CODE_NONE;
      reject_nxt = ev_both | ((state == PENDING) & bus.open & new_valid);
   end

   // Hand-off FSM with registered coin code, reject pulse and reject count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= EMPTY;
         pend_code    <= CODE_NONE;
         coins_q      <= CODE_NONE;
         reject_q     <= 1'b0;
         reject_cnt_q <= '0;
      end else begin
         coins_q  <= CODE_NONE;
         reject_q <= reject_nxt;
         if (reject_nxt && (reject_cnt_q != {REJ_W{1'b1}})) begin
            reject_cnt_q <= reject_cnt_q + 1'b1;
         end

         case (state)
            EMPTY: begin
               if (new_valid) begin
                  if (bus.open) begin
                     pend_code <= new_code;
                     state     <= PENDING;
                  end else begin
                     coins_q <= new_code;
                  end
               end
            end
            PENDING: begin
               // While open stays high the parked coin is held; any new
               // coin is bounced via reject_nxt. Once open drops, the
               // parked coin goes first and a same-cycle arrival takes its slot.
               if (!bus.open) begin
                  coins_q <= pend_code;
                  if (new_valid) begin
                     pend_code <= new_code;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

   assign bus.coins      = coins_q;
   assign bus.reject     = reject_q;
   assign bus.reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a table of per-cycle vectors followed
// by a hand-written reject-counter saturation sequence.
module tb_coin_acceptor;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   coin_acceptor_if #(.REJ_W(8)) bus ();

   coin_acceptor #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3),
      .REJ_W          (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      int         test;
      logic       n;
      logic       d;
      logic       o;
      logic       r;
      logic [1:0] coins;
      logic       rej;
      logic [7:0] cnt;
   } vec_t;

   vec_t       vecs[$];
   int         nvec = 0;
   int         nerr = 0;
   logic [7:0] cnt_e;

   task automatic add(input int t, input logic n, input logic d, input logic o,
                      input logic r, input logic [1:0] c, input logic rj);
      vec_t v;
      if (r)  cnt_e = 8'd0;
      if (rj) cnt_e = cnt_e + 8'd1;
      v.test  = t;
      v.n     = n;
      v.d     = d;
      v.o     = o;
      v.r     = r;
      v.coins = c;
      v.rej   = rj;
      v.cnt   = cnt_e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;
      logic bad_code;

      bus.nickel_in = 1'b0;
      bus.dime_in   = 1'b0;
      bus.open      = 1'b0;
      reset         = 1'b1;
      cnt_e         = 8'd0;

      // reset state
      add(0, 0, 0, 0, 1, 2'b00, 0);
      // 1: clean nickel, code exactly 7 edges after first sample
      for (int i = 0; i < 18; i++) add(1, i < 10, 0, 0, 0, (i == 7) ? 2'b01 : 2'b00, 0);
      // 2: two-cycle dime glitch is ignored
      for (int i = 0; i < 10; i++) add(2, 0, i < 2, 0, 0, 2'b00, 0);
      // 3: nickel and dime together -> reject
      for (int i = 0; i < 18; i++) add(3, i < 10, i < 10, 0, 0, 2'b00, i == 7);
      // 4: dime parked while open, released the cycle open falls
      for (int i = 0; i < 21; i++)
         add(4, 0, (i >= 2) && (i <= 9), i <= 11, 0, (i == 12) ? 2'b10 : 2'b00, 0);
      // 5: dime parked, nickel arrives while still open -> reject, dime once
      for (int i = 0; i < 26; i++)
         add(5, (i >= 8) && (i <= 13), i <= 5, i <= 16, 0, (i == 17) ? 2'b10 : 2'b00, i == 15);
      // 6: reset while PENDING and mid-debounce discards everything
      for (int i = 0; i < 21; i++)
         add(6, i <= 5, (i >= 8) && (i <= 10), i <= 10, i == 10, 2'b00, 0);
      // 6b: sensor held through reset debounces again, one event
      for (int i = 0; i < 23; i++)
         add(7, i <= 14, 0, 0, i == 3, (i == 11) ? 2'b01 : 2'b00, 0);

      foreach (vecs[k]) begin
         bus.nickel_in = vecs[k].n;
         bus.dime_in   = vecs[k].d;
         bus.open      = vecs[k].o;
         reset         = vecs[k].r;
         step();
         check($sformatf("t%0d_coins", vecs[k].test), k, {30'd0, bus.coins}, {30'd0, vecs[k].coins});
         check($sformatf("t%0d_reject", vecs[k].test), k, {31'd0, bus.reject}, {31'd0, vecs[k].rej});
         check($sformatf("t%0d_reject_cnt", vecs[k].test), k, {24'd0, bus.reject_cnt}, {24'd0, vecs[k].cnt});
      end

      // 7: 256 ambiguous insertions, counter saturates at 255
      bus.nickel_in = 1'b0;
      bus.dime_in   = 1'b0;
      bus.open      = 1'b0;
      reset         = 1'b1;
      step();
      check("sat_reset_cnt", 0, {24'd0, bus.reject_cnt}, 32'd0);
      reset    = 1'b0;
      seen     = 0;
      bad_code = 1'b0;
      for (int p = 0; p < 256; p++) begin
         for (int c = 0; c < 12; c++) begin
            bus.nickel_in = (c < 6);
            bus.dime_in   = (c < 6);
            step();
            if (bus.reject === 1'b1) seen++;
            if (bus.coins !== 2'b00) bad_code = 1'b1;
         end
         if (p == 253) check("sat_cnt_254", p, {24'd0, bus.reject_cnt}, 32'd254);
         if (p == 254) check("sat_cnt_255", p, {24'd0, bus.reject_cnt}, 32'd255);
         if (p == 255) check("sat_cnt_hold", p, {24'd0, bus.reject_cnt}, 32'd255);
      end
      check("sat_reject_pulses", 0, seen, 32'd256);
      check("sat_no_code", 0, {31'd0, bad_code}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
